stream_rate_monitor_10g: RTL and testbench
==========================================

Name: stream_rate_monitor_10g

Overview:
- Receive-side checker for the 10G multi-stream scheduler's grant interface (current_id / valid / pause_enable).
- Accumulates granted frame bytes per stream over a fixed window of line-time cycles, then snapshots the totals into a readout bank.
- Host logic or a bench reads the bank via a simple request/response port to verify configured bandwidth shares.
- Sits beside the scheduler in the 156.25 MHz, 64-bit (8 bytes/cycle) transmit domain.

Parameters:
- NUM_STREAMS, 64, number of stream ids monitored (valid ids 1..NUM_STREAMS).
- WINDOW_CYCLES, 1000000, unpaused clock cycles per measurement window (6.4 ms at 156.25 MHz).
- ACC_W, 32, width of each per-stream byte accumulator.

Ports:
- clock  in  1  transmit clock, 156.25 MHz.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  monitoring enable (tied to tx_enable); low behaves as reset for counters.
- pause_enable  in  1  scheduler paused; cycle excluded from line time.
- current_id  in  16  stream id from scheduler.
- valid  in  8  scheduler valid; 8'b10000000 = frame grant for current_id.
- frame_len  in  16  byte length of granted frame, sampled on grant cycle.
- window_done  out  1  one-cycle pulse when a new snapshot is readable.
- window_count  out  16  number of completed windows, wraps.
- line_bytes  out  ACC_W  8 x WINDOW_CYCLES of last window (constant after first window).
- bad_grants  out  16  grants with id 0 or id > NUM_STREAMS in last window, saturating.
- rd_req  in  1  readout request.
- rd_id  in  16  stream id to read, sampled with rd_req.
- rd_valid  out  1  readout response strobe.
- rd_data  out  ACC_W  snapshot byte total for rd_id.

Behaviour:
- Reset/enable low: all accumulators, snapshot bank, window timer, window_count, bad_grants, line_bytes = 0; window_done = 0, rd_valid = 0, rd_data = 0.
- Grant detect: valid == 8'h80 with enable high. Any other nonzero valid pattern is ignored (no count, no error).
- Grant on id 1..NUM_STREAMS: acc[id] += frame_len, saturates at 2^ACC_W-1.
- Grant on bad id: bad counter += 1, saturates at 16'hFFFF.
- Grants are counted even if pause_enable is high on the same cycle.
- Window timer: increments on cycles with enable=1 and pause_enable=0; holds while paused.
- Boundary cycle: timer reaches WINDOW_CYCLES-1 and the cycle is unpaused.
  - Next edge: copy acc[] and the bad counter to the snapshot bank; include a grant on the boundary cycle in the closing window.
  - Same edge: clear acc[] and the bad counter, timer -> 0, window_count += 1, line_bytes <= 8*WINDOW_CYCLES, window_done = 1 for exactly one cycle.
- Grant on the cycle after the boundary: counted in the new window.
- Readout: rd_req samples rd_id; rd_valid and rd_data follow exactly 1 cycle later.
  - rd_data = snapshot[rd_id]; returns 0 for id 0 or id > NUM_STREAMS.
  - Back-to-back requests allowed, one per cycle.
  - If the snapshot swaps on the edge that registers rd_data, rd_data returns the new snapshot value.
- Storage: accumulators may be a register array or inferred dual-port RAM. One update per cycle suffices because the scheduler issues at most one grant per cycle.
- Reset mid-window: discards the partial window; the snapshot reads 0 until the first window completes.
- Arithmetic: frame_len is zero-extended to ACC_W. No wrap-around on accumulators; window_count wraps at 16 bits.

Test Plan:
1. WINDOW_CYCLES=100. Grant id 1 len 84 every 10 unpaused cycles. After window_done, rd_id=1 -> rd_data=840 one cycle later; line_bytes=800.
2. Same stimulus with pause_enable high for 50 cycles mid-window -> window_done arrives 50 cycles later; rd_data still 840.
3. Grants on id 0 and id 65 (3 total) plus id 2 len 2000 -> bad_grants=3, snapshot[2]=2000; reading rd_id 65 returns 0.
4. Grant id 3 len 64 on the boundary cycle and again on the next cycle -> snapshot[3]=64 for the closing window; next window's snapshot[3] includes the second 64.
5. Pre-load acc[4] near 2^32 (ACC_W=32) via repeated len 65535 grants -> snapshot[4]=32'hFFFFFFFF; no wrap.
6. Assert reset for 1 cycle mid-window after several grants -> window_done, bad_grants, and all snapshot reads are 0 until the next full window completes.

Source files
------------

// File: rtl/stream_rate_monitor_10g.sv
// Per-stream granted-byte monitor for the 10G scheduler grant interface.
// Accumulates frame bytes per stream over a window of unpaused cycles and
// snapshots the totals into a bank readable through a 1-cycle read port.
module stream_rate_monitor_10g #(
    parameter int unsigned NUM_STREAMS   = 64,
    parameter int unsigned WINDOW_CYCLES = 1000000,
    parameter int unsigned ACC_W         = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             pause_enable,
    input  logic [15:0]      current_id,
    input  logic [7:0]       valid,
    input  logic [15:0]      frame_len,
    output logic             window_done,
    output logic [15:0]      window_count,
    output logic [ACC_W-1:0] line_bytes,
    output logic [15:0]      bad_grants,
    input  logic             rd_req,
    input  logic [15:0]      rd_id,
    output logic             rd_valid,
    output logic [ACC_W-1:0] rd_data
);

    localparam int unsigned IDX_W = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam int unsigned TMR_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [ACC_W-1:0] LINE_BYTES = ACC_W'(8 * WINDOW_CYCLES);
    localparam logic [15:0]      ID_MAX     = 16'(NUM_STREAMS);

    logic [ACC_W-1:0] acc_q  [NUM_STREAMS];
    logic [ACC_W-1:0] acc_d  [NUM_STREAMS];
    logic [ACC_W-1:0] snap_q [NUM_STREAMS];
    logic [ACC_W-1:0] snap_d [NUM_STREAMS];
    logic [15:0]      bad_cnt_q, bad_cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             window_done_q, window_done_d;
    logic [15:0]      window_count_q, window_count_d;
    logic [ACC_W-1:0] line_bytes_q, line_bytes_d;
    logic [15:0]      bad_grants_q, bad_grants_d;
    logic             rd_valid_q, rd_valid_d;
    logic [ACC_W-1:0] rd_data_q, rd_data_d;

    logic             grant_c;
    logic             id_ok_c;
    logic             rd_ok_c;
    logic             boundary_c;
    logic [IDX_W-1:0] id_idx_c;
    logic [IDX_W-1:0] rd_idx_c;
    logic [SUM_W-1:0] acc_sum_c;

    // Grant decode, id range checks and saturating accumulator sum
    always_comb begin
        grant_c    = enable && (valid == 8'h80);
        id_ok_c    = (current_id != 16'd0) && (current_id <= ID_MAX);
        rd_ok_c    = (rd_id != 16'd0) && (rd_id <= ID_MAX);
        boundary_c = enable && !pause_enable && (timer_q == TMR_LAST);
        id_idx_c   = IDX_W'(current_id - 16'd1);
        rd_idx_c   = IDX_W'(rd_id - 16'd1);
        acc_sum_c  = {1'b0, acc_q[id_idx_c]} + SUM_W'(frame_len);
    end

    // Next-state: accumulate, close window on boundary, serve readout
    always_comb begin
        acc_d          = acc_q;
        snap_d         = snap_q;
        bad_cnt_d      = bad_cnt_q;
        timer_d        = timer_q;
        window_done_d  = 1'b0;
        window_count_d = window_count_q;
        line_bytes_d   = line_bytes_q;
        bad_grants_d   = bad_grants_q;
        rd_valid_d     = 1'b0;
        rd_data_d      = '0;

        if (!enable) begin
            acc_d          = '{default: '0};
            snap_d         = '{default: '0};
            bad_cnt_d      = 16'd0;
            timer_d        = '0;
            window_count_d = 16'd0;
            line_bytes_d   = '0;
            bad_grants_d   = 16'd0;
        end else begin
            if (grant_c && id_ok_c) begin
                acc_d[id_idx_c] = acc_sum_c[ACC_W] ? {ACC_W{1'b1}} : acc_sum_c[ACC_W-1:0];
            end
            if (grant_c && !id_ok_c && (bad_cnt_q != 16'hFFFF)) begin
                bad_cnt_d = bad_cnt_q + 16'd1;
            end
            if (!pause_enable) begin
                timer_d = timer_q + TMR_W'(1);
            end
            // Boundary grant is already folded into acc_d/bad_cnt_d here
            if (boundary_c) begin
                snap_d         = acc_d;
                bad_grants_d   = bad_cnt_d;
                acc_d          = '{default: '0};
                bad_cnt_d      = 16'd0;
                timer_d        = '0;
                window_count_d = window_count_q + 16'd1;
                line_bytes_d   = LINE_BYTES;
                window_done_d  = 1'b1;
            end
            // Reads see the snapshot being written on the same edge
            rd_valid_d = rd_req;
            if (rd_req && rd_ok_c) begin
                rd_data_d = snap_d[rd_idx_c];
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q          <= '{default: '0};
            snap_q         <= '{default: '0};
            bad_cnt_q      <= 16'd0;
            timer_q        <= '0;
            window_done_q  <= 1'b0;
            window_count_q <= 16'd0;
            line_bytes_q   <= '0;
            bad_grants_q   <= 16'd0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
        end else begin
            acc_q          <= acc_d;
            snap_q         <= snap_d;
            bad_cnt_q      <= bad_cnt_d;
            timer_q        <= timer_d;
            window_done_q  <= window_done_d;
            window_count_q <= window_count_d;
            line_bytes_q   <= line_bytes_d;
            bad_grants_q   <= bad_grants_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
        end
    end

    assign window_done  = window_done_q;
    assign window_count = window_count_q;
    assign line_bytes   = line_bytes_q;
    assign bad_grants   = bad_grants_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_stream_rate_monitor_10g.sv
// Bench for stream_rate_monitor_10g: directed window scenarios with a read
// scoreboard (expected read data queued at request, popped on rd_valid).
module tb_stream_rate_monitor_10g;

    localparam int unsigned NS = 64;
    localparam int unsigned WC = 100;
    localparam int unsigned AW = 24;

    logic          clock;
    logic          reset;
    logic          enable;
    logic          pause_enable;
    logic [15:0]   current_id;
    logic [7:0]    valid;
    logic [15:0]   frame_len;
    logic          window_done;
    logic [15:0]   window_count;
    logic [AW-1:0] line_bytes;
    logic [15:0]   bad_grants;
    logic          rd_req;
    logic [15:0]   rd_id;
    logic          rd_valid;
    logic [AW-1:0] rd_data;

    int checks   = 0;
    int failures = 0;
    logic [AW-1:0] exp_q[$];

    stream_rate_monitor_10g #(
        .NUM_STREAMS  (NS),
        .WINDOW_CYCLES(WC),
        .ACC_W        (AW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .pause_enable(pause_enable),
        .current_id  (current_id),
        .valid       (valid),
        .frame_len   (frame_len),
        .window_done (window_done),
        .window_count(window_count),
        .line_bytes  (line_bytes),
        .bad_grants  (bad_grants),
        .rd_req      (rd_req),
        .rd_id       (rd_id),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        valid      = 8'h00;
        current_id = 16'd0;
        frame_len  = 16'd0;
        rd_req     = 1'b0;
        rd_id      = 16'd0;
    endtask

    task automatic grant(input logic [15:0] id, input logic [15:0] len);
        valid      = 8'h80;
        current_id = id;
        frame_len  = len;
    endtask

    // Drive a read request and queue its expected response
    task automatic read(input logic [15:0] id, input logic [AW-1:0] e);
        rd_req = 1'b1;
        rd_id  = id;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        clear_in();
        pause_enable = 1'b0;
        enable       = 1'b1;
        reset        = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [AW-1:0] e;
        clear_in();
        enable = 1'b1;
        pause_enable = 1'b0;
        reset = 1'b1;
        read(16'd1, '0);
        tick();
        tick();
        exp_q.delete();
        checks++;
        if ({window_done, window_count, line_bytes, bad_grants, rd_valid, rd_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got done=%0b cnt=%0d line=%0d bad=%0d rdv=%0b rdd=%0d, want all 0",
                     window_done, window_count, line_bytes, bad_grants, rd_valid, rd_data);
        end
        // Enable low must also hold everything cleared, even with a grant and read
        reset = 1'b0;
        enable = 1'b0;
        grant(16'd1, 16'd10);
        rd_req = 1'b1;
        rd_id = 16'd1;
        tick();
        checks++;
        if ({window_done, window_count, line_bytes, bad_grants, rd_valid} !== '0) begin
            failures++;
            $display("FAIL enable_low: got done=%0b cnt=%0d line=%0d bad=%0d rdv=%0b, want all 0",
                     window_done, window_count, line_bytes, bad_grants, rd_valid);
        end
        e = '0;
        clear_in();
    endtask

    task automatic test_basic_window();
        int done_at = -1;
        logic [AW-1:0] e;
        do_reset();
        for (int t = 0; t < 103; t++) begin
            clear_in();
            if (t < 100 && (t % 10) == 0) grant(16'd1, 16'd84);
            if (t == 100) read(16'd1, AW'(840));
            if (t == 101) read(16'd2, '0);
            tick();
            if (window_done && done_at < 0) done_at = t;
            if (t == 99) begin
                checks++;
                if (window_count !== 16'd1 || line_bytes !== AW'(800) || bad_grants !== 16'd0) begin
                    failures++;
                    $display("FAIL basic_status: cnt=%0d line=%0d bad=%0d, want 1 800 0",
                             window_count, line_bytes, bad_grants);
                end
            end
            if (t == 100) begin
                checks++;
                if (window_done !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_pulse_width: window_done=%0b one cycle after, want 0", window_done);
                end
            end
            if (rd_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL basic_rd: unexpected rd_valid data=%0d", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rd_data !== e) begin
                        failures++;
                        $display("FAIL basic_rd: got %0d want %0d", rd_data, e);
                    end
                end
            end
        end
        checks++;
        if (done_at != 99 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL basic_timing: done_at=%0d want 99, pending reads=%0d want 0", done_at, exp_q.size());
        end
    endtask

    task automatic test_pause();
        int done_at = -1;
        int u = 0;
        logic [AW-1:0] e;
        do_reset();
        for (int t = 0; t < 153; t++) begin
            clear_in();
            pause_enable = (t >= 45 && t < 95);
            if (!pause_enable && u < 100 && (u % 10) == 0) grant(16'd1, 16'd84);
            if (t == 150) read(16'd1, AW'(840));
            if (!pause_enable) u++;
            tick();
            if (window_done && done_at < 0) done_at = t;
            if (rd_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL pause_rd: unexpected rd_valid data=%0d", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rd_data !== e) begin
                        failures++;
                        $display("FAIL pause_rd: got %0d want %0d", rd_data, e);
                    end
                end
            end
        end
        pause_enable = 1'b0;
        checks++;
        if (done_at != 149 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL pause_timing: done_at=%0d want 149, pending reads=%0d want 0", done_at, exp_q.size());
        end
    endtask

    task automatic test_bad_ids();
        int done_at = -1;
        logic [AW-1:0] e;
        do_reset();
        for (int t = 0; t < 106; t++) begin
            clear_in();
            pause_enable = (t == 8);
            case (t)
                5:  grant(16'd0, 16'd100);
                6:  grant(16'd65, 16'd100);
                7:  grant(16'd0, 16'd100);
                8:  grant(16'd2, 16'd2000);
                9:  begin grant(16'd2, 16'd500); valid = 8'h01; end
                10: begin grant(16'd2, 16'd500); valid = 8'hC0; end
                101: read(16'd2, AW'(2000));
                102: read(16'd65, '0);
                103: read(16'd0, '0);
                104: read(16'd64, '0);
                default: ;
            endcase
            tick();
            if (window_done && done_at < 0) done_at = t;
            if (t == 100) begin
                checks++;
                if (bad_grants !== 16'd3) begin
                    failures++;
                    $display("FAIL bad_count: got %0d want 3", bad_grants);
                end
            end
            if (rd_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL bad_rd: unexpected rd_valid data=%0d", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rd_data !== e) begin
                        failures++;
                        $display("FAIL bad_rd: got %0d want %0d", rd_data, e);
                    end
                end
            end
        end
        pause_enable = 1'b0;
        checks++;
        if (done_at != 100 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bad_timing: done_at=%0d want 100, pending reads=%0d want 0", done_at, exp_q.size());
        end
    endtask

    task automatic test_boundary_grant();
        logic [AW-1:0] e;
        do_reset();
        for (int t = 0; t < 202; t++) begin
            clear_in();
            if (t == 99 || t == 100) grant(16'd3, 16'd64);
            if (t == 150) grant(16'd3, 16'd100);
            if (t == 100) read(16'd3, AW'(64));
            // Read registered on the swap edge returns the new snapshot
            if (t == 199) read(16'd3, AW'(164));
            if (t == 200) read(16'd3, AW'(164));
            tick();
            if (t == 99 || t == 199) begin
                checks++;
                if (window_done !== 1'b1 || window_count !== 16'((t + 1) / 100)) begin
                    failures++;
                    $display("FAIL boundary_done t=%0d: done=%0b cnt=%0d, want 1 %0d",
                             t, window_done, window_count, (t + 1) / 100);
                end
            end
            if (rd_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL boundary_rd: unexpected rd_valid data=%0d", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rd_data !== e) begin
                        failures++;
                        $display("FAIL boundary_rd t=%0d: got %0d want %0d", t, rd_data, e);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL boundary_pending: %0d reads unanswered, want 0", exp_q.size());
        end
    endtask

    task automatic test_saturation();
        int done_at = -1;
        logic [AW-1:0] e;
        do_reset();
        for (int t = 0; t < 403; t++) begin
            clear_in();
            pause_enable = (t < 300);
            if (t < 300) grant(16'd4, 16'hFFFF);
            if (t == 400) read(16'd4, {AW{1'b1}});
            tick();
            if (window_done && done_at < 0) done_at = t;
            if (rd_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sat_rd: unexpected rd_valid data=%0d", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rd_data !== e) begin
                        failures++;
                        $display("FAIL sat_rd: got %0h want %0h", rd_data, e);
                    end
                end
            end
        end
        pause_enable = 1'b0;
        checks++;
        if (done_at != 399 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL sat_timing: done_at=%0d want 399, pending reads=%0d want 0", done_at, exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        int done_at = -1;
        logic [AW-1:0] e;
        do_reset();
        for (int t = 0; t < 154; t++) begin
            clear_in();
            reset = (t == 50);
            if (t < 5) grant(16'd5, 16'd100);
            if (t == 5) grant(16'd0, 16'd1);
            if (t == 60) grant(16'd5, 16'd7);
            if (t == 51) read(16'd5, '0);
            if (t == 52) read(16'd1, '0);
            if (t == 151) read(16'd5, AW'(7));
            tick();
            if (window_done && done_at < 0) done_at = t;
            if (t == 50) begin
                checks++;
                if ({window_done, window_count, line_bytes, bad_grants} !== '0) begin
                    failures++;
                    $display("FAIL midreset_clear: done=%0b cnt=%0d line=%0d bad=%0d, want all 0",
                             window_done, window_count, line_bytes, bad_grants);
                end
            end
            if (t == 150) begin
                checks++;
                if (window_count !== 16'd1 || bad_grants !== 16'd0) begin
                    failures++;
                    $display("FAIL midreset_window: cnt=%0d bad=%0d, want 1 0", window_count, bad_grants);
                end
            end
            if (rd_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL midreset_rd: unexpected rd_valid data=%0d", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rd_data !== e) begin
                        failures++;
                        $display("FAIL midreset_rd t=%0d: got %0d want %0d", t, rd_data, e);
                    end
                end
            end
        end
        reset = 1'b0;
        checks++;
        if (done_at != 150 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_timing: done_at=%0d want 150, pending reads=%0d want 0", done_at, exp_q.size());
        end
    endtask

    initial begin
        clear_in();
        reset        = 1'b1;
        enable       = 1'b0;
        pause_enable = 1'b0;
        test_reset();
        test_basic_window();
        test_pause();
        test_bad_ids();
        test_boundary_grant();
        test_saturation();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
